// File: rtl/wptr_full_gen.sv
// Write-domain pointer, full/almost_full/level and overflow control for a dual-clock FIFO.
// Optional sticky overflow flag and wen/full assertion enabled by WPTR_OVERFLOW_CHECK_EN.
module wptr_full_gen #(
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int AF_MARGIN   = 1
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [$clog2(DEPTH):0]   rptr_gray,
  input  logic                     ovf_clr,
  output logic                     wen,
  output logic [$clog2(DEPTH)-1:0] waddr,
  output logic [$clog2(DEPTH):0]   wptr_gray,
  output logic                     full,
  output logic                     almost_full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int A  = $clog2(DEPTH);
  localparam int PW = A + 1;
  localparam logic [PW-1:0] AF_TH = PW'(DEPTH - AF_MARGIN);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] wgray_next;
  logic [PW-1:0] rq [SYNC_STAGES];
  logic [PW-1:0] rq_sync;
  logic [PW-1:0] rbin_sync;
  logic [PW-1:0] full_cmp;
  logic [PW-1:0] lvl_next;

  assign wen        = push & ~full;
  assign waddr      = wbin[A-1:0];
  assign wbin_next  = wbin + PW'(wen);
  assign wgray_next = wbin_next ^ (wbin_next >> 1);
  assign rq_sync    = rq[SYNC_STAGES-1];
  // Full when write is exactly one lap ahead: top two Gray bits inverted.
  assign full_cmp   = {~rq_sync[A:A-1], rq_sync[A-2:0]};
  assign lvl_next   = wbin_next - rbin_sync;

  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i < PW; i++)
      rbin_sync[i] = ^(rq_sync >> i);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        rq[i] <= '0;
    end else begin
      rq[0] <= rptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++)
        rq[i] <= rq[i-1];
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      level       <= '0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= (wgray_next == full_cmp);
      almost_full <= (lvl_next >= AF_TH);
      level       <= lvl_next;
    end
  end

`ifdef WPTR_OVERFLOW_CHECK_EN
  // Set has priority over clear so a simultaneous overrun is never lost.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)
      overflow <= 1'b0;
    else if (push & full)
      overflow <= 1'b1;
    else if (ovf_clr)
      overflow <= 1'b0;
  end

  a_no_wen_full: assert property (
    @(posedge clock) disable iff (!resetn) !(wen && full));
`else
  logic unused_ovf_clr;

  assign overflow       = 1'b0;
  assign unused_ovf_clr = ovf_clr;
`endif

endmodule

// File: tb/tb_wptr_full_gen.sv
// Self-checking bench for wptr_full_gen with an occupancy-count reference model.
// Expects overflow behaviour according to WPTR_OVERFLOW_CHECK_EN.
module tb_wptr_full_gen;

  localparam int DEPTH = 8;
  localparam int S     = 2;
  localparam int AFM   = 1;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic       push = 1'b0;
  logic       ovf_clr = 1'b0;
  logic [3:0] rptr_gray = '0;
  logic       wen;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       full;
  logic       almost_full;
  logic [3:0] level;
  logic       overflow;

  wptr_full_gen #(
    .DEPTH(DEPTH),
    .SYNC_STAGES(S),
    .AF_MARGIN(AFM)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .push(push),
    .rptr_gray(rptr_gray),
    .ovf_clr(ovf_clr),
    .wen(wen),
    .waddr(waddr),
    .wptr_gray(wptr_gray),
    .full(full),
    .almost_full(almost_full),
    .level(level),
    .overflow(overflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  // Reference model: counts of words written/read, read count seen after S edges.
  int wtot;
  int rd;
  int hist[$];
  int m_level;
  bit m_full;
  bit m_af;
  bit m_ovf;

  function automatic logic [3:0] gray(int v);
    logic [3:0] b;
    b = 4'(v % 16);
    return b ^ (b >> 1);
  endfunction

  function automatic bit m_ovf_exp();
`ifdef WPTR_OVERFLOW_CHECK_EN
    return m_ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_clear();
    wtot = 0;
    rd = 0;
    hist.delete();
    m_level = 0;
    m_full = 0;
    m_af = 0;
    m_ovf = 0;
  endtask

  task automatic drive(bit p, bit c);
    push = p;
    ovf_clr = c;
    rptr_gray = gray(rd);
  endtask

  task automatic tick();
    int rs;
    bit acc;
    @(posedge clock);
    acc = push && !m_full;
    if (push && m_full) m_ovf = 1;
    else if (ovf_clr) m_ovf = 0;
    wtot += int'(acc);
    rs = (hist.size() >= S) ? hist[hist.size()-S] : 0;
    hist.push_back(rd);
    m_level = wtot - rs;
    m_full = (m_level == DEPTH);
    m_af = (m_level >= DEPTH - AFM);
    @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    push = 1'b0;
    ovf_clr = 1'b0;
    model_clear();
    rptr_gray = '0;
    #1;
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    #1;
    total++; if (wptr_gray !== 4'd0) begin bad++; $display("FAIL rst_gray got %0d want 0", wptr_gray); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got %0d want 0", full); end
    total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL rst_af got %0d want 0", almost_full); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL rst_level got %0d want 0", level); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf got %0d want 0", overflow); end
    total++; if (waddr !== 3'd0) begin bad++; $display("FAIL rst_waddr got %0d want 0", waddr); end
    model_clear();
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_fill();
    logic [3:0] gseq [8];
    gseq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(1, 0);
      #1;
      total++; if (waddr !== 3'(i)) begin bad++; $display("FAIL fill_waddr[%0d] got %0d want %0d", i, waddr, i); end
      total++; if (wen !== 1'b1) begin bad++; $display("FAIL fill_wen[%0d] got %0d want 1", i, wen); end
      tick();
      total++; if (wptr_gray !== gseq[i]) begin bad++; $display("FAIL fill_gray[%0d] got %0d want %0d", i, wptr_gray, gseq[i]); end
      total++; if (almost_full !== (i >= 6)) begin bad++; $display("FAIL fill_af[%0d] got %0d want %0d", i, almost_full, i >= 6); end
      total++; if (full !== (i == 7)) begin bad++; $display("FAIL fill_full[%0d] got %0d want %0d", i, full, i == 7); end
      total++; if (level !== 4'(i + 1)) begin bad++; $display("FAIL fill_level[%0d] got %0d want %0d", i, level, i + 1); end
    end
  endtask

  task automatic test_overflow();
    bit want;
`ifdef WPTR_OVERFLOW_CHECK_EN
    want = 1'b1;
`else
    want = 1'b0;
`endif
    drive(1, 0);
    #1;
    total++; if (wen !== 1'b0) begin bad++; $display("FAIL ovf_wen got %0d want 0", wen); end
    tick();
    total++; if (wptr_gray !== 4'd12) begin bad++; $display("FAIL ovf_gray got %0d want 12", wptr_gray); end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL ovf_full got %0d want 1", full); end
    total++; if (overflow !== want) begin bad++; $display("FAIL ovf_flag got %0d want %0d", overflow, want); end
    drive(0, 0);
  endtask

  task automatic test_drain_latency();
    int lat;
    int lvl;
    lat = 0;
    lvl = -1;
    rd = 1;
    drive(0, 0);
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      tick();
      if (!full) begin
        lat = n;
        lvl = int'(level);
      end
    end
    total++; if (lat !== S + 1) begin bad++; $display("FAIL drain_lat got %0d want %0d", lat, S + 1); end
    total++; if (lvl !== 7) begin bad++; $display("FAIL drain_level got %0d want 7", lvl); end
    drive(1, 0);
    #1;
    total++; if (wen !== 1'b1) begin bad++; $display("FAIL drain_wen got %0d want 1", wen); end
    total++; if (waddr !== 3'd0) begin bad++; $display("FAIL drain_waddr got %0d want 0", waddr); end
    tick();
    total++; if (level !== 4'(m_level)) begin bad++; $display("FAIL drain_level2 got %0d want %0d", level, m_level); end
    total++; if (full !== m_full) begin bad++; $display("FAIL drain_full2 got %0d want %0d", full, m_full); end
    drive(0, 0);
  endtask

  task automatic test_stream();
    logic [3:0] prev;
    logic [2:0] pa;
    bit wrap_a;
    bit wrap_g;
    wrap_a = 0;
    wrap_g = 0;
    do_reset();
    prev = wptr_gray;
    for (int i = 0; i < 20; i++) begin
      rd = (wtot > 2) ? wtot - 2 : 0;
      drive(1, 0);
      #1;
      total++; if (wen !== 1'b1) begin bad++; $display("FAIL strm_wen[%0d] got %0d want 1", i, wen); end
      pa = waddr;
      tick();
      if (pa == 3'd7 && waddr == 3'd0) wrap_a = 1;
      if (prev == 4'd8 && wptr_gray == 4'd0) wrap_g = 1;
      total++; if (full !== 1'b0) begin bad++; $display("FAIL strm_full[%0d] got %0d want 0", i, full); end
      total++; if (wptr_gray !== gray(wtot)) begin bad++; $display("FAIL strm_gray[%0d] got %0d want %0d", i, wptr_gray, gray(wtot)); end
      total++; if ($countones(wptr_gray ^ prev) != 1) begin bad++; $display("FAIL strm_1bit[%0d] got %0d->%0d want one bit", i, prev, wptr_gray); end
      prev = wptr_gray;
    end
    total++; if (wrap_a !== 1'b1) begin bad++; $display("FAIL strm_addr_wrap got %0d want 1", wrap_a); end
    total++; if (wrap_g !== 1'b1) begin bad++; $display("FAIL strm_gray_wrap got %0d want 1", wrap_g); end
    drive(0, 0);
  endtask

  task automatic test_midreset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0);
      tick();
    end
    total++; if (level !== 4'd5) begin bad++; $display("FAIL mr_level5 got %0d want 5", level); end
    drive(1, 0);
    #2 resetn = 1'b0;
    #1;
    total++; if (wptr_gray !== 4'd0) begin bad++; $display("FAIL mr_gray got %0d want 0", wptr_gray); end
    total++; if (level !== 4'd0) begin bad++; $display("FAIL mr_level got %0d want 0", level); end
    total++; if (full !== 1'b0 || almost_full !== 1'b0) begin bad++; $display("FAIL mr_flags got %0d%0d want 00", full, almost_full); end
    total++; if (waddr !== 3'd0) begin bad++; $display("FAIL mr_waddr got %0d want 0", waddr); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mr_ovf got %0d want 0", overflow); end
    push = 1'b0;
    model_clear();
    rptr_gray = '0;
    #1 resetn = 1'b1;
    tick();
    drive(1, 0);
    #1;
    total++; if (waddr !== 3'd0 || wen !== 1'b1) begin bad++; $display("FAIL mr_first got a%0d/e%0d want a0/e1", waddr, wen); end
    tick();
    total++; if (wptr_gray !== 4'd1) begin bad++; $display("FAIL mr_gray1 got %0d want 1", wptr_gray); end
    drive(0, 0);
  endtask

  task automatic test_random();
    bit p;
    bit c;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (rd < wtot && $urandom_range(1, 0) == 1) rd++;
      p = $urandom_range(99, 0) < (((n / 50) % 2 == 0) ? 90 : 30);
      c = $urandom_range(9, 0) == 0;
      drive(p, c);
      #1;
      total++; if (wen !== (p && !m_full)) begin bad++; $display("FAIL rnd_wen[%0d] got %0d want %0d", n, wen, p && !m_full); end
      total++; if (waddr !== 3'(wtot % 8)) begin bad++; $display("FAIL rnd_waddr[%0d] got %0d want %0d", n, waddr, wtot % 8); end
      tick();
      total++; if (wptr_gray !== gray(wtot)) begin bad++; $display("FAIL rnd_gray[%0d] got %0d want %0d", n, wptr_gray, gray(wtot)); end
      total++; if (level !== 4'(m_level)) begin bad++; $display("FAIL rnd_level[%0d] got %0d want %0d", n, level, m_level); end
      total++; if (full !== m_full) begin bad++; $display("FAIL rnd_full[%0d] got %0d want %0d", n, full, m_full); end
      total++; if (almost_full !== m_af) begin bad++; $display("FAIL rnd_af[%0d] got %0d want %0d", n, almost_full, m_af); end
      total++; if (overflow !== m_ovf_exp()) begin bad++; $display("FAIL rnd_ovf[%0d] got %0d want %0d", n, overflow, m_ovf_exp()); end
    end
    drive(0, 0);
  endtask

  task automatic test_ovf_clr();
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(1, 0);
      tick();
    end
`ifdef WPTR_OVERFLOW_CHECK_EN
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL oc_set got %0d want 1", overflow); end
    drive(0, 1);
    tick();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL oc_clr got %0d want 0", overflow); end
    drive(1, 1);
    tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL oc_setwins got %0d want 1", overflow); end
    drive(0, 0);
    tick();
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL oc_sticky got %0d want 1", overflow); end
`else
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL oc_off got %0d want 0", overflow); end
    drive(1, 1);
    tick();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL oc_off2 got %0d want 0", overflow); end
`endif
    total++; if (full !== 1'b1) begin bad++; $display("FAIL oc_full got %0d want 1", full); end
    drive(0, 0);
  endtask

  initial begin
    model_clear();
    test_reset();
    test_fill();
    test_overflow();
    test_drain_latency();
    test_stream();
    test_midreset();
    test_random();
    test_ovf_clr();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
